// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for serial_adder.
// Optional macro SERIAL_ADDER_SUB_EN adds the 'sub' request line.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output sum, cout, ovf, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN enables subtraction (a - b) via bus.sub.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder_if.slave    bus
);
  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             carry_s;
  logic [WIDTH-1:0] acc_next;

  // Subtraction is folded into the operand latch: b is inverted and the
  // carry seeded with 1, so the run phase is the same full adder either way.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    bit_s    = a_q[0] ^ b_q[0] ^ c_q;
    carry_s  = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    acc_next = {bit_s, acc_q[WIDTH-1:1]};

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub ? 1'b1   : bus.cin;
`else
          b_d     = bus.b;
          c_d     = bus.cin;
`endif
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = carry_s;
        acc_d = acc_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = acc_next;
          cout_d  = carry_s;
          ovf_d   = c_q ^ carry_s;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb, input logic [7:0] es,
                        input logic ec, input logic eo);
    logic [7:0] prev;
    int         n;
    logic       hold_bad;
    prev     = bus.sum;
    hold_bad = 1'b0;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sb;
`endif
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = 8'h5A;
    bus.cin   = ~ci;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = ~sb;
`else
    if (sb) $display("note: sub ignored in addition-only build");
`endif
    check({tag, "_busy"}, bus.busy, 1'b1);
    n = 0;
    while (!bus.done && n < 20) begin
      step();
      n++;
      if (!bus.done && bus.sum !== prev) hold_bad = 1'b1;
    end
    check({tag, "_lat"}, n, 8);
    check({tag, "_hold"}, hold_bad, 1'b0);
    check({tag, "_sum"}, bus.sum, es);
    check({tag, "_cout"}, bus.cout, ec);
    check({tag, "_ovf"}, bus.ovf, eo);
    step();
    check({tag, "_pulse"}, bus.done, 1'b0);
    check({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    int n;
    int pulses;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    #1;
    check("rst_sum", bus.sum, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    #11 rst_n = 1'b1;
    step();

    run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("ff_p1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("7f_p1", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("cin", 8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0);

    // start pulsed mid-run must be ignored
    bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(n);
    check("ign_lat", n + 3, 8);
    check("ign_sum", bus.sum, 8'h30);
    step();

    // start held high: back-to-back operations
    bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0; bus.start = 1'b1;
    step();
    bus.a = 8'h90; bus.b = 8'h90;
    wait_done(n);
    check("b2b_lat1", n, 8);
    check("b2b_sum1", bus.sum, 8'h03);
    step();
    check("b2b_busy", bus.busy, 1'b1);
    check("b2b_nodone", bus.done, 1'b0);
    check("b2b_holdsum", bus.sum, 8'h03);
    bus.start = 1'b0;
    bus.a = 8'h00; bus.b = 8'h00;
    wait_done(n);
    check("b2b_period", n + 1, 9);
    check("b2b_sum2", bus.sum, 8'h20);
    check("b2b_cout2", bus.cout, 1'b1);
    check("b2b_ovf2", bus.ovf, 1'b1);
    step();
    check("b2b_idle", bus.busy, 1'b0);
    check("b2b_keep", bus.sum, 8'h20);

    // reset mid-run
    bus.a = 8'h11; bus.b = 8'h22; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum", bus.sum, 8'h00);
    check("arst_cout", bus.cout, 1'b0);
    check("arst_ovf", bus.ovf, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done) pulses++;
    end
    check("arst_nodone", pulses, 0);
    run_op("post_rst", 8'h21, 8'h43, 1'b0, 1'b0, 8'h64, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_neg", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_pos", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new addition; sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 SHALL have port sum  output  WIDTH  registered result of the last completed operation.
REQ-009 SHALL have port cout  output  1  registered carry-out of the last completed operation.
REQ-010 SHALL have port ovf  output  1  registered signed overflow (carry into MSB XOR carry out of MSB).
REQ-011 SHALL have port busy  output  1  high while bits are being processed.
REQ-012 SHALL have port done  output  1  one-cycle pulse when sum/cout/ovf are updated.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL latch a, b, cin into internal registers, clear the bit counter, and enter RUN.
REQ-015 In DONE with start=0, the FSM SHALL return to IDLE on the next edge.
REQ-016 In RUN, each edge SHALL process one bit, LSB first: bit = a[i] XOR b[i] XOR c; c <= majority(a[i], b[i], c); counter increments.
REQ-017 After the edge that processes bit WIDTH-1, the FSM SHALL enter DONE, load sum, cout, ovf, and assert done for exactly that cycle.
REQ-018 Latency SHALL be exactly WIDTH cycles: start accepted at edge E0 -> done high after edge E_WIDTH.
REQ-019 busy SHALL be 1 exactly when the state is RUN.
REQ-020 start while in RUN SHALL be ignored; latched operands SHALL not change.
REQ-021 Back-to-back: start=1 during the done cycle SHALL be accepted with no idle gap.
REQ-022 sum, cout, ovf SHALL change only on entry to DONE; they SHALL hold their value during subsequent RUN cycles.
REQ-023 Result SHALL equal (a + b + cin) mod 2^WIDTH, with cout the bit-WIDTH carry.
REQ-024 Changes on a, b, cin outside an accepting edge SHALL not affect the result.

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk, force state IDLE and set sum=0, cout=0, ovf=0, busy=0, done=0, and clear internal registers.
REQ-026 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where start=1.

Configuration
REQ-028 With macro SERIAL_ADDER_SUB_EN defined, the block SHALL have an extra input sub (1 bit, sampled with the operands).
REQ-029 With SERIAL_ADDER_SUB_EN defined and sub=1, the result SHALL be a + ~b + 1 (a - b), cin ignored; cout=1 means no borrow.
REQ-030 With SERIAL_ADDER_SUB_EN undefined, the sub port SHALL not exist, and behaviour SHALL be addition only.

Verification (WIDTH=8)
REQ-031 Reset, then a=8'h00, b=8'h00, cin=0, start for one cycle -> busy high 8 cycles; done after edge 8; sum=8'h00, cout=0, ovf=0.
REQ-032 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1; a=8'h3C, b=8'h0F, cin=1 -> sum=8'h4C, cout=0.
REQ-033 Start 8'h10+8'h20; pulse start with 8'hFF+8'hFF at cycle 3 -> ignored; sum=8'h30 at done.
REQ-034 Hold start high through done -> second operation begins with no gap; done pulses every 9 cycles; sum stays at the first result until the second done.
REQ-035 rst_n low mid-RUN (cycle 4) -> outputs 0 asynchronously; no done; the next start completes normally.
REQ-036 With SERIAL_ADDER_SUB_EN defined, sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0; a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
